instr_encoder: RTL

Program-loader-side instruction encoder: the inverse of `control_logic`. Accepts one symbolic instruction per handshake (mnemonic plus register, immediate and address fields), packs it into the 16-bit machine word that `control_logic` decodes, and emits each word with a sequential instruction-memory address over a valid/ready write port. It sits between the host or boot sequencer and the instruction memory. It tracks load state, word count, memory-full and illegal-input conditions.

---
 rtl/instr_encoder.sv | 138 +++++++++++++
 1 files changed

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - symbolic instruction to 16-bit machine word encoder with sequential imem write port
// Optional strict field checking: define INSTR_ENC_STRICT_EN.
module instr_encoder #(
    parameter logic [7:0] BASE_ADDR = 8'h00,
    parameter logic [7:0] MAX_ADDR  = 8'hFF
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        start,
    input  logic        stop,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  mnem,
    input  logic [3:0]  ra,
    input  logic [3:0]  rb,
    input  logic [3:0]  rc,
    input  logic [7:0]  imm,
    input  logic [7:0]  addr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  imem_addr,
    output logic [15:0] imem_wdata,
    output logic        busy,
    output logic        full,
    output logic        err_illegal,
    output logic [8:0]  count
);

    typedef enum logic {S_IDLE, S_LOAD} state_t;

    state_t      r_state, w_state_nxt;
    logic        r_out_valid, r_full, r_err;
    logic [7:0]  r_ptr, r_addr;
    logic [15:0] r_wdata;
    logic [8:0]  r_count;

    logic        w_accept, w_emit, w_last, w_illegal;
    logic [7:0]  w_wr_addr;
    logic [15:0] w_enc;

    assign busy      = (r_state == S_LOAD);
    assign in_ready  = busy & ~r_full & (~r_out_valid | out_ready);
    assign w_accept  = in_valid & in_ready;
    assign w_emit    = r_out_valid & out_ready;
    // Emitting MAX_ADDR ends the session; a word accepted in that same cycle has nowhere to go.
    assign w_last    = w_emit & (r_addr == MAX_ADDR);
    assign w_wr_addr = w_emit ? r_ptr + 8'd1 : r_ptr;

    always_comb begin
        w_enc     = 16'h0000;
        w_illegal = 1'b0;
        case (mnem)
            5'd0:                      w_enc = 16'h0000;
            5'd1:                      w_enc = {4'h1, rc, addr};
            5'd2:                      w_enc = {4'h2, rc, rb, imm[3:0]};
            5'd3:                      w_enc = {4'h3, ra, addr};
            5'd4:                      w_enc = {4'h4, rc, imm};
            5'd5, 5'd6, 5'd7, 5'd8:    w_enc = {mnem[3:0], rc, ra, rb};
            5'd9, 5'd10, 5'd11:        w_enc = {mnem[3:0] + 4'd1, rc, ra, rb};
            5'd12:                     w_enc = {4'hD, ra, addr};
            5'd13:                     w_enc = {4'hE, ra, addr};
            5'd14:                     w_enc = {4'hF, 4'h0, addr};
            5'd15:                     w_enc = 16'hF100;
            5'd16:                     w_enc = 16'hF200;
            5'd17, 5'd18, 5'd19, 5'd20,
            5'd21, 5'd22, 5'd23:       w_enc = {4'hF, mnem[3:0] + 4'd2, rc, imm[3:0]};
            default:                   w_illegal = 1'b1;
        endcase
`ifdef INSTR_ENC_STRICT_EN
        if ((mnem == 5'd2 || (mnem >= 5'd17 && mnem <= 5'd23)) && imm[7:4] != 4'h0)
            w_illegal = 1'b1;
        if (mnem == 5'd14 && ra != 4'h0)
            w_illegal = 1'b1;
`else
        w_illegal = w_illegal;
`endif
    end

    always_comb begin
        w_state_nxt = r_state;
        if (start)
            w_state_nxt = S_LOAD;
        else if (r_state == S_LOAD && (stop || w_last))
            w_state_nxt = S_IDLE;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_full      <= 1'b0;
            r_err       <= 1'b0;
            r_ptr       <= 8'h00;
            r_addr      <= 8'h00;
            r_wdata     <= 16'h0000;
            r_count     <= 9'd0;
        end else begin
            r_state <= w_state_nxt;
            if (start) begin
                // Restart drops any pending word; an input accepted this cycle opens the new session.
                r_ptr       <= BASE_ADDR;
                r_count     <= 9'd0;
                r_full      <= 1'b0;
                r_err       <= w_accept & w_illegal;
                r_out_valid <= w_accept & ~w_illegal;
                if (w_accept & ~w_illegal) begin
                    r_addr  <= BASE_ADDR;
                    r_wdata <= w_enc;
                end
            end else begin
                if (w_emit) begin
                    r_count <= r_count + 9'd1;
                    if (r_addr == MAX_ADDR)
                        r_full <= 1'b1;
                    else
                        r_ptr <= r_ptr + 8'd1;
                end
                if (w_accept & w_illegal)
                    r_err <= 1'b1;
                if (w_accept & ~w_illegal & ~w_last) begin
                    r_out_valid <= 1'b1;
                    r_addr      <= w_wr_addr;
                    r_wdata     <= w_enc;
                end else if (w_emit) begin
                    r_out_valid <= 1'b0;
                end
            end
        end
    end

    assign out_valid   = r_out_valid;
    assign imem_addr   = r_addr;
    assign imem_wdata  = r_wdata;
    assign full        = r_full;
    assign err_illegal = r_err;
    assign count       = r_count;

endmodule
